wb_classic_controller: RTL and testbench
========================================

WB_CLASSIC_CONTROLLER -- requirements
Module: wb_classic_controller

Interface
REQ-001 Parameter DAT_WIDTH, default 8: data bus width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADR_WIDTH, default 16: address bus width in bits.
REQ-003 Parameter SEL_WIDTH, default DAT_WIDTH/8: one byte-select bit per byte lane.
REQ-004 Parameter MAX_RETRY, default 3: number of retries allowed after rty_i before the command is abandoned.
REQ-005 Parameter TIMEOUT, default 16: cycles to wait for a response per attempt; 0 disables the timeout.
REQ-006 Parameter RETRY_GAP, default 1, minimum 1: idle cycles with cyc_o low between retry attempts.
REQ-007 One clock; reset is asynchronous and active-high. Clock port clk_i, reset port rst_i.
REQ-008 Ports, in order:
- clk_i  in  1  clock
- rst_i  in  1  async active-high reset
- cmd_valid_i  in  1  command offered
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i
- cmd_we_i  in  1  1 = write, 0 = read
- cmd_adr_i  in  ADR_WIDTH  address
- cmd_dat_i  in  DAT_WIDTH  write data
- cmd_sel_i  in  SEL_WIDTH  byte selects
- rsp_valid_o  out  1  response available
- rsp_ready_i  in  1  response consumed
- rsp_dat_o  out  DAT_WIDTH  read data; 0 for writes and for failed commands
- rsp_status_o  out  2  00 OK, 01 ERR, 10 RETRY_EXHAUSTED, 11 TIMEOUT
- cyc_o, stb_o, we_o  out  1 each  Wishbone classic controller signals
- adr_o  out  ADR_WIDTH  Wishbone address
- dat_o  out  DAT_WIDTH  Wishbone write data
- sel_o  out  SEL_WIDTH  Wishbone byte selects
- ack_i, err_i, rty_i  in  1 each  Wishbone terminations
- dat_i  in  DAT_WIDTH  Wishbone read data

Function
REQ-009 The FSM SHALL have four states: IDLE, REQ, GAP and RESP.
REQ-010 In IDLE, cmd_ready_o SHALL be 1 and is 0 in every other state. A handshake SHALL capture we, adr, dat and sel into holding registers, clear the retry and timeout counters, and move the FSM to REQ.
REQ-011 In REQ, cyc_o and stb_o SHALL be 1, and we_o, adr_o, dat_o and sel_o SHALL drive the holding registers unchanged until the attempt terminates.
REQ-012 In every state other than REQ, cyc_o, stb_o and we_o SHALL be 0; adr_o, dat_o and sel_o hold their last values.
REQ-013 Terminations SHALL be sampled only in REQ. ack_i, err_i or rty_i seen in any other state SHALL be ignored.
REQ-014 Termination priority when several are high in the same cycle SHALL be err_i > rty_i > ack_i.
REQ-015 On ack_i in REQ: for a read, rsp_dat_o is loaded with dat_i; for a write, rsp_dat_o is 0. Status is OK and the next state is RESP, so cyc_o falls on the following edge.
REQ-016 On err_i in REQ: status is ERR, rsp_dat_o is 0, and the next state is RESP.
REQ-017 On rty_i in REQ with retry count < MAX_RETRY: the retry count increments and the next state is GAP.
REQ-018 On rty_i in REQ with retry count == MAX_RETRY: status is RETRY_EXHAUSTED, rsp_dat_o is 0, and the next state is RESP.
REQ-019 GAP SHALL last exactly RETRY_GAP cycles and then return to REQ with the same holding-register contents and the timeout counter cleared.
REQ-020 When TIMEOUT > 0, the timeout counter SHALL count REQ cycles without a termination. Reaching TIMEOUT sets status TIMEOUT, rsp_dat_o = 0 and moves to RESP, so cyc_o is high for exactly TIMEOUT cycles.
REQ-021 A termination arriving in the same cycle the timeout expires SHALL take precedence over the timeout.
REQ-022 In RESP, rsp_valid_o SHALL be 1 and rsp_dat_o and rsp_status_o SHALL be stable until rsp_ready_i is seen; the FSM then returns to IDLE on the next edge.
REQ-023 Minimum command-to-command spacing: accept at cycle 0, cyc_o at cycle 1, ack at cycle 1, rsp_valid_o at cycle 2, IDLE and cmd_ready_o at cycle 3 when rsp_ready_i = 1.
REQ-024 Counter widths SHALL be sized from MAX_RETRY, TIMEOUT and RETRY_GAP so that no counter wraps.

Reset
REQ-025 While rst_i is high, and immediately on its assertion, the block SHALL:
- enter IDLE
- drive cyc_o, stb_o, we_o, rsp_valid_o = 0 and cmd_ready_o = 1
- clear adr_o, dat_o, sel_o, rsp_dat_o, rsp_status_o and all counters to 0
REQ-026 Reset asserted mid-cycle SHALL drop cyc_o asynchronously, discard the pending command and produce no response.

Verification
REQ-027 Read, ack on the 3rd REQ cycle: adr 0x0010, dat_i 0xA5 -> cyc_o high for 3 cycles, then rsp_valid_o with rsp_dat_o = 0xA5 and status 00.
REQ-028 Write, immediate ack: adr 0x0002, dat 0x3C, sel 1 -> we_o = 1 for 1 cycle, then rsp_dat_o = 0 and status 00.
REQ-029 rty_i on every attempt with MAX_RETRY = 3 -> 4 cyc_o pulses separated by 1 low cycle, then status 10.
REQ-030 No termination with TIMEOUT = 16 -> cyc_o high exactly 16 cycles, then status 11. With err_i and ack_i together -> status 01.
REQ-031 rst_i asserted in the 2nd REQ cycle -> cyc_o low in the same cycle, no rsp_valid_o; a subsequent command completes normally.
REQ-032 rsp_ready_i held low 5 cycles -> rsp_valid_o, rsp_dat_o and rsp_status_o stable throughout, and cmd_ready_o stays 0.

Source files
------------

// File: rtl/wb_classic_controller.sv
// rtl/wb_classic_controller.sv - Wishbone classic controller: one command in, one bus cycle with retry/timeout, one response out
module wb_classic_controller #(
  parameter int DAT_WIDTH = 8,
  parameter int ADR_WIDTH = 16,
  parameter int SEL_WIDTH = DAT_WIDTH / 8,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 16,
  parameter int RETRY_GAP = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_we_i,
  input  logic [ADR_WIDTH-1:0] cmd_adr_i,
  input  logic [DAT_WIDTH-1:0] cmd_dat_i,
  input  logic [SEL_WIDTH-1:0] cmd_sel_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DAT_WIDTH-1:0] rsp_dat_o,
  output logic [1:0]           rsp_status_o,
  output logic                 cyc_o,
  output logic                 stb_o,
  output logic                 we_o,
  output logic [ADR_WIDTH-1:0] adr_o,
  output logic [DAT_WIDTH-1:0] dat_o,
  output logic [SEL_WIDTH-1:0] sel_o,
  input  logic                 ack_i,
  input  logic                 err_i,
  input  logic                 rty_i,
  input  logic [DAT_WIDTH-1:0] dat_i
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int GW = $clog2(RETRY_GAP + 1);

  localparam logic [1:0] ST_OK = 2'b00, ST_ERR = 2'b01, ST_RTY = 2'b10, ST_TMO = 2'b11;

  typedef enum logic [1:0] {IDLE, REQ, GAP, RESP} state_t;
  state_t state, state_n;

  logic          we_q;
  logic [RW-1:0] retry_cnt;
  logic [TW-1:0] to_cnt;
  logic [GW-1:0] gap_cnt;
  logic          retry_last, to_expire, gap_done;

  assign retry_last = (retry_cnt == RW'(MAX_RETRY));
  assign to_expire  = (TIMEOUT > 0) && (to_cnt == TW'(TIMEOUT - 1));
  assign gap_done   = (gap_cnt == GW'(RETRY_GAP - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (cmd_valid_i) state_n = REQ;
      REQ: begin
        if (err_i)            state_n = RESP;
        else if (rty_i)       state_n = retry_last ? RESP : GAP;
        else if (ack_i)       state_n = RESP;
        else if (to_expire)   state_n = RESP;
      end
      GAP:  if (gap_done)    state_n = REQ;
      RESP: if (rsp_ready_i) state_n = IDLE;
      default:               state_n = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o = 1'b0;
    cyc_o       = 1'b0;
    stb_o       = 1'b0;
    we_o        = 1'b0;
    rsp_valid_o = 1'b0;
    case (state)
      IDLE: cmd_ready_o = 1'b1;
      REQ: begin
        cyc_o = 1'b1;
        stb_o = 1'b1;
        we_o  = we_q;
      end
      RESP:    rsp_valid_o = 1'b1;
      default: ;
    endcase
  end

  // Holding registers drive the bus directly, so they also "hold last value" outside REQ.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q         <= 1'b0;
      adr_o        <= '0;
      dat_o        <= '0;
      sel_o        <= '0;
      rsp_dat_o    <= '0;
      rsp_status_o <= ST_OK;
      retry_cnt    <= '0;
      to_cnt       <= '0;
      gap_cnt      <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid_i) begin
          we_q      <= cmd_we_i;
          adr_o     <= cmd_adr_i;
          dat_o     <= cmd_dat_i;
          sel_o     <= cmd_sel_i;
          retry_cnt <= '0;
          to_cnt    <= '0;
        end
        REQ: begin
          if (err_i) begin
            rsp_status_o <= ST_ERR;
            rsp_dat_o    <= '0;
          end else if (rty_i) begin
            if (retry_last) begin
              rsp_status_o <= ST_RTY;
              rsp_dat_o    <= '0;
            end else begin
              retry_cnt <= retry_cnt + RW'(1);
              to_cnt    <= '0;
              gap_cnt   <= '0;
            end
          end else if (ack_i) begin
            rsp_status_o <= ST_OK;
            rsp_dat_o    <= we_q ? '0 : dat_i;
          end else if (to_expire) begin
            rsp_status_o <= ST_TMO;
            rsp_dat_o    <= '0;
          end else if (TIMEOUT > 0) begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + GW'(1);
          to_cnt  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_classic_controller.sv
// tb/tb_wb_classic_controller.sv - directed self-checking bench for wb_classic_controller
module tb_wb_classic_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [15:0] cmd_adr = '0, adr_o;
  logic [7:0]  cmd_dat = '0, dat_o, rsp_dat, dat_in = '0;
  logic [0:0]  cmd_sel = '0, sel_o;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [1:0]  rsp_status;
  logic        cyc, stb, we_o;
  logic        ack = 1'b0, err = 1'b0, rty = 1'b0;

  int n_asserts = 0;
  int n_fails   = 0;
  int cyc_hi, pulses, gap_lo, we_seen;

  always #5 clk = ~clk;

  wb_classic_controller dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_dat_o(rsp_dat), .rsp_status_o(rsp_status),
    .cyc_o(cyc), .stb_o(stb), .we_o(we_o),
    .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o),
    .ack_i(ack), .err_i(err), .rty_i(rty), .dat_i(dat_in)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: ack on REQ cycle ack_at of an attempt; 1: rty on every attempt (ack driven while cyc low);
  // 2: never terminate; 3: err and ack together on the first REQ cycle
  task automatic run_cmd(input logic w, input logic [15:0] a, input logic [7:0] d, input logic [7:0] din,
                         input int mode, input int ack_at);
    int att;
    bit prev, done;
    cyc_hi = 0; pulses = 0; gap_lo = 0; we_seen = 0; att = 0; prev = 0; done = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = 1'b1; dat_in = din;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (rsp_valid) begin done = 1; break; end
      ack = 1'b0; err = 1'b0; rty = 1'b0;
      if (cyc) begin
        if (!prev) pulses++;
        cyc_hi++; att++;
        if (we_o) we_seen++;
        case (mode)
          0: ack = (att == ack_at);
          1: rty = (att == 1);
          3: begin err = (att == 1); ack = (att == 1); end
          default: ;
        endcase
      end else begin
        att = 0;
        if (pulses > 0) gap_lo++;
        if (mode == 1) ack = 1'b1;
      end
      prev = cyc;
      @(negedge clk);
    end
    ack = 1'b0; err = 1'b0; rty = 1'b0;
    if (!done) chk("rsp_wait_timeout", 0, 1);
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("idle_cmd_ready", 32'(cmd_ready), 1);
    chk("idle_rsp_valid", 32'(rsp_valid), 0);
  endtask

  initial begin
    // reset state
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_cyc", 32'(cyc), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_adr", 32'(adr_o), 0);
    chk("rst_status", 32'(rsp_status), 0);
    @(negedge clk);
    rst = 1'b0;

    // read, ack on 3rd REQ cycle
    run_cmd(1'b0, 16'h0010, 8'h00, 8'hA5, 0, 3);
    chk("rd_cyc_hi", cyc_hi, 3);
    chk("rd_dat", 32'(rsp_dat), 'hA5);
    chk("rd_status", 32'(rsp_status), 0);
    chk("rd_adr_hold", 32'(adr_o), 'h0010);
    chk("rd_we", we_seen, 0);
    // response held off for 5 cycles
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 1);
      chk("hold_dat", 32'(rsp_dat), 'hA5);
      chk("hold_status", 32'(rsp_status), 0);
      chk("hold_cmd_ready", 32'(cmd_ready), 0);
    end
    finish_rsp();

    // write, immediate ack; read data on the bus must not leak into the response
    run_cmd(1'b1, 16'h0002, 8'h3C, 8'hFF, 0, 1);
    chk("wr_cyc_hi", cyc_hi, 1);
    chk("wr_we_cycles", we_seen, 1);
    chk("wr_dat_o", 32'(dat_o), 'h3C);
    chk("wr_sel_o", 32'(sel_o), 1);
    chk("wr_rsp_dat", 32'(rsp_dat), 0);
    chk("wr_status", 32'(rsp_status), 0);
    finish_rsp();

    // retry on every attempt, ack during gaps must be ignored
    run_cmd(1'b0, 16'h0040, 8'h00, 8'h77, 1, 0);
    chk("rty_pulses", pulses, 4);
    chk("rty_cyc_hi", cyc_hi, 4);
    chk("rty_gap_lo", gap_lo, 3);
    chk("rty_status", 32'(rsp_status), 2);
    chk("rty_dat", 32'(rsp_dat), 0);
    finish_rsp();

    // no termination -> timeout after 16 cycles
    run_cmd(1'b0, 16'h0050, 8'h00, 8'h11, 2, 0);
    chk("tmo_cyc_hi", cyc_hi, 16);
    chk("tmo_pulses", pulses, 1);
    chk("tmo_status", 32'(rsp_status), 3);
    chk("tmo_dat", 32'(rsp_dat), 0);
    finish_rsp();

    // ack in the very cycle the timeout expires wins
    run_cmd(1'b0, 16'h0051, 8'h00, 8'h5A, 0, 16);
    chk("tmo_ack_cyc_hi", cyc_hi, 16);
    chk("tmo_ack_status", 32'(rsp_status), 0);
    chk("tmo_ack_dat", 32'(rsp_dat), 'h5A);
    finish_rsp();

    // err and ack together -> ERR
    run_cmd(1'b0, 16'h0060, 8'h00, 8'h99, 3, 0);
    chk("err_status", 32'(rsp_status), 1);
    chk("err_dat", 32'(rsp_dat), 0);
    finish_rsp();

    // reset in the 2nd REQ cycle
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 16'h0077; cmd_dat = 8'h44;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mid_cyc_before", 32'(cyc), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_cyc_async", 32'(cyc), 0);
    chk("mid_adr_clr", 32'(adr_o), 0);
    chk("mid_cmd_ready", 32'(cmd_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_no_rsp", 32'(rsp_valid), 0);
      chk("mid_no_cyc", 32'(cyc), 0);
    end
    run_cmd(1'b0, 16'h0123, 8'h00, 8'hC3, 0, 2);
    chk("post_rst_cyc_hi", cyc_hi, 2);
    chk("post_rst_dat", 32'(rsp_dat), 'hC3);
    chk("post_rst_status", 32'(rsp_status), 0);
    finish_rsp();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
